// File: rtl/mod_div_scheduler_if.sv
// Request/response bundle for the shared divide/modulo sequencer.
// master drives requests and consumes results; slave is the sequencer.
interface mod_div_scheduler_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 16
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_op;
  logic [N_REQ*WIDTH-1:0] req_num;
  logic [N_REQ*WIDTH-1:0] req_den;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic [1:0]             rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_dbz;
  logic                   rsp_ready;

  modport master (
    output req_valid, req_op, req_num, req_den, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_dbz
  );

  modport slave (
    input  req_valid, req_op, req_num, req_den, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_dbz
  );
endinterface

// File: rtl/mod_div_scheduler.sv
// Round-robin arbiter feeding one iterative restoring divider.
// One quotient/remainder per grant, returned over valid/ready.
module mod_div_scheduler #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  mod_div_scheduler_if.slave  bus,
  output logic                busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             gnt_found;
  logic [1:0]       gnt_idx;
  logic [2:0]       scan;
  logic             sel_op;
  logic [WIDTH-1:0] sel_num, sel_den;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr_q} + 3'(k);
      if (scan >= 3'(N_REQ)) scan = scan - 3'(N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (!gnt_found && scan == 3'(i)
            && bus.req_valid[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    sel_op  = 1'b0;
    sel_num = '0;
    sel_den = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_op  = bus.req_op[i];
        sel_num = bus.req_num[i*WIDTH +: WIDTH];
        sel_den = bus.req_den[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_ready[i] = rst && (state_q == IDLE)
                         && gnt_found && (gnt_idx == 2'(i));
    end
  end

  // trial sign bit decides restore vs. keep
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, den_q};
  assign rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0]
                               : trial[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dbz_d   = dbz_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          op_d  = sel_op;
          id_d  = gnt_idx;
          den_d = sel_den;
          ptr_d = (gnt_idx == 2'(N_REQ - 1))
                  ? 2'd0 : gnt_idx + 2'd1;
          if (sel_den == '0) begin
            data_d  = '0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = sel_num;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          data_d  = op_q ? rem_nx : quo_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      dbz_q   <= 1'b0;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dbz_q   <= dbz_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      data_q  <= data_d;
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_dbz   = dbz_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mod_div_scheduler.sv
// Directed bench for mod_div_scheduler: arbitration order, latency,
// backpressure, boundary operands and asynchronous reset.
module tb_mod_div_scheduler;
  localparam int N = 2;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  mod_div_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus ();

  mod_div_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input int id, input logic op,
                       input logic [W-1:0] num, input logic [W-1:0] den);
    int waited = 0;
    bus.req_op[id]             = op;
    bus.req_num[id*W +: W]     = num;
    bus.req_den[id*W +: W]     = den;
    bus.req_valid[id]          = 1'b1;
    #1;
    while (!bus.req_ready[id] && waited < 50) begin
      step();
      waited++;
    end
    check({tag, ".grant"}, 32'(bus.req_ready[id]), 1);
    step();
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic op_check(input string tag, input int id, input logic op,
                          input logic [W-1:0] num, input logic [W-1:0] den,
                          input logic [W-1:0] exp_data, input logic exp_dbz);
    int lat;
    issue(tag, id, op, num, den);
    wait_rsp(lat);
    check({tag, ".lat"},   32'(lat), exp_dbz ? 1 : W + 1);
    check({tag, ".valid"}, 32'(bus.rsp_valid), 1);
    check({tag, ".data"},  32'(bus.rsp_data), 32'(exp_data));
    check({tag, ".dbz"},   32'(bus.rsp_dbz), 32'(exp_dbz));
    check({tag, ".id"},    32'(bus.rsp_id), 32'(id));
    consume();
    check({tag, ".idle"},  32'(busy), 0);
  endtask

  task automatic serve(input logic [N-1:0] keep, output int who);
    int waited = 0;
    int lat;
    #1;
    while (bus.req_ready == '0 && waited < 50) begin
      step();
      waited++;
    end
    who = bus.req_ready[1] ? 1 : (bus.req_ready[0] ? 0 : -1);
    step();
    if (who >= 0 && !keep[who]) bus.req_valid[who] = 1'b0;
    wait_rsp(lat);
    consume();
  endtask

  initial begin
    int who;
    int lat;
    int seen;

    rst           = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_op    = '0;
    bus.req_num   = '0;
    bus.req_den   = '0;
    bus.rsp_ready = 1'b0;
    #3;
    check("rst.valid", 32'(bus.rsp_valid), 0);
    check("rst.busy",  32'(busy), 0);
    check("rst.ready", 32'(bus.req_ready), 0);
    check("rst.data",  32'(bus.rsp_data), 0);
    check("rst.id",    32'(bus.rsp_id), 0);
    check("rst.dbz",   32'(bus.rsp_dbz), 0);
    step();
    step();
    bus.req_valid = '0;
    rst           = 1'b1;
    #1;

    // round robin from a fresh pointer
    bus.req_num = {16'd8, 16'd9};
    bus.req_den = {16'd4, 16'd3};
    bus.req_valid = 2'b11;
    serve(2'b00, who); check("rr.first0",  32'(who), 0);
    serve(2'b00, who); check("rr.first1",  32'(who), 1);
    bus.req_valid = 2'b11;
    serve(2'b00, who); check("rr.again0",  32'(who), 0);
    serve(2'b00, who); check("rr.again1",  32'(who), 1);
    bus.req_valid = 2'b11;
    serve(2'b11, who); check("rr.alt0",    32'(who), 0);
    serve(2'b11, who); check("rr.alt1",    32'(who), 1);
    serve(2'b11, who); check("rr.alt2",    32'(who), 0);
    serve(2'b11, who); check("rr.alt3",    32'(who), 1);
    bus.req_valid = '0;

    op_check("div100_7", 0, 1'b0, 16'd100, 16'd7, 16'd14, 1'b0);
    op_check("mod100_7", 0, 1'b1, 16'd100, 16'd7, 16'd2,  1'b0);
    op_check("mod5_0",   1, 1'b1, 16'd5,   16'd0, 16'd0,  1'b1);

    // backpressure with a competing request pending
    issue("bp", 0, 1'b0, 16'd50, 16'd5);
    bus.req_op[1]       = 1'b0;
    bus.req_num[W +: W] = 16'd7;
    bus.req_den[W +: W] = 16'd1;
    bus.req_valid[1]    = 1'b1;
    wait_rsp(lat);
    check("bp.lat", 32'(lat), W + 1);
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 32'(bus.rsp_valid), 1);
      check("bp.data",  32'(bus.rsp_data), 10);
      check("bp.id",    32'(bus.rsp_id), 0);
      check("bp.ready", 32'(bus.req_ready), 0);
      check("bp.busy",  32'(busy), 1);
      step();
    end
    consume();
    check("bp.idle",    32'(busy), 0);
    check("bp.nextgnt", 32'(bus.req_ready), 2);
    bus.req_valid[1] = 1'b0;

    op_check("ffff_mod_1",    0, 1'b1, 16'hFFFF, 16'd1,    16'd0,    1'b0);
    op_check("ffff_div_ffff", 1, 1'b0, 16'hFFFF, 16'hFFFF, 16'd1,    1'b0);
    op_check("3_div_8",       0, 1'b0, 16'd3,    16'd8,    16'd0,    1'b0);
    op_check("3_mod_8",       1, 1'b1, 16'd3,    16'd8,    16'd3,    1'b0);
    op_check("0_div_5",       0, 1'b0, 16'd0,    16'd5,    16'd0,    1'b0);
    op_check("ffff_div_2",    1, 1'b0, 16'hFFFF, 16'd2,    16'h7FFF, 1'b0);
    op_check("1000_mod_3",    0, 1'b1, 16'd1000, 16'd3,    16'd1,    1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         o;
      a = 16'($urandom);
      b = 16'($urandom_range(1, 65535));
      o = 1'($urandom_range(0, 1));
      op_check($sformatf("rnd%0d", i), i % 2, o, a, b,
               o ? a % b : a / b, 1'b0);
    end

    // reset in the middle of RUN
    issue("mid", 0, 1'b0, 16'd1000, 16'd3);
    repeat (7) step();
    check("mid.busy_pre", 32'(busy), 1);
    bus.req_valid[1] = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("mid.valid", 32'(bus.rsp_valid), 0);
    check("mid.busy",  32'(busy), 0);
    check("mid.ready", 32'(bus.req_ready), 0);
    check("mid.data",  32'(bus.rsp_data), 0);
    check("mid.id",    32'(bus.rsp_id), 0);
    check("mid.dbz",   32'(bus.rsp_dbz), 0);
    step();
    step();
    check("mid.ready_hold", 32'(bus.req_ready), 0);
    rst           = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    check("mid.ptr0", 32'(bus.req_ready), 1);
    bus.req_valid = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rsp_valid) seen++;
    end
    check("mid.norsp", 32'(seen), 0);
    op_check("post_rst", 0, 1'b0, 16'd1000, 16'd3, 16'd333, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mod_div_scheduler.md
# mod_div_scheduler

Shared sequencer for the arithmetic section of the ALU. It takes 16-bit divide/modulo requests from several requesters, grants one at a time by round-robin, and runs each through a single iterative restoring divider. It returns the quotient or remainder with a valid/ready response handshake. It replaces per-requester single-cycle `%`/`/` hardware with one shared multi-cycle unit.

## Interface
- `N_REQ`, default 2: number of requesters, 2..4.
- `WIDTH`, default 16: operand and result width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: request pending, one bit per requester.
- `req_op` in N_REQ: per requester, 0 = DIV (quotient), 1 = MOD (remainder).
- `req_num` in N_REQ*WIDTH: numerators, requester i in bits [i*WIDTH +: WIDTH].
- `req_den` in N_REQ*WIDTH: denominators, same packing as `req_num`.
- `req_ready` out N_REQ: grant. At most one bit high.
- `rsp_valid` out 1: result available.
- `rsp_id` out 2: index of the requester that owns the result.
- `rsp_data` out WIDTH: quotient or remainder.
- `rsp_dbz` out 1: divide-by-zero flag.
- `rsp_ready` in 1: consumer accepts the result.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `req_ready[g]` = 1 only for the winner g, combinationally. g is the first set `req_valid` bit searching from the pointer `ptr` upward, with wrap-around.
  - A request is accepted when `req_valid[g]` and `req_ready[g]` are both high at a clock edge. On acceptance:
    - op, num, den and id are latched.
    - `ptr` <= (g+1) mod N_REQ.
    - If den == 0: go to DONE with rsp_data = 0 and rsp_dbz = 1.
    - Otherwise: go to RUN with remainder register = 0, quotient register = num, step counter = 0.
- **RUN**, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem - den, computed at WIDTH+1 bits.
  - If trial is non-negative: rem <= trial and quo[0] <= 1. Otherwise quo[0] <= 0.
  - After WIDTH steps: go to DONE. rsp_data = quo for DIV, rem for MOD. rsp_dbz = 0.
- **DONE**
  - `rsp_valid` = 1. `rsp_id`, `rsp_data` and `rsp_dbz` are held stable.
  - When `rsp_ready` = 1 at an edge: go to IDLE and clear `rsp_valid`.
- `req_ready` is 0 in RUN and DONE. Requesters must hold `req_valid`, op and operands stable until they are granted.
- Operands are latched at acceptance. Changing the inputs afterwards does not affect the operation in flight.
- Unsigned arithmetic only. Results match `num / den` and `num % den` for all den != 0.
- Simultaneous requests never lose a requester. Round-robin guarantees that each waiting requester is served within N_REQ operations.
- `rsp_id` for an out-of-range requester index is not possible; `g` is always less than N_REQ.

## Timing
- Reset (`rst` low): asynchronously forces the following, regardless of state, including mid-RUN or mid-DONE:
  - state = IDLE, ptr = 0, step counter = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_dbz = 0, busy = 0.
  - `req_ready` = 0 while `rst` is low.
  - An operation in flight is discarded and no response is produced.
- Handshake accepted at the end of cycle t:
  - den != 0: `rsp_valid` is high from cycle t+1+WIDTH (cycle t+17 at the defaults).
  - den == 0: `rsp_valid` is high from cycle t+1.
- Response consumed at the end of cycle u: IDLE in cycle u+1, and the next grant can be accepted at the end of cycle u+1.
- Throughput: one operation per WIDTH+2 cycles with `rsp_ready` tied high.
- `busy` is high from cycle t+1 through cycle u.
- `rsp_ready` low in DONE: the block stalls indefinitely and no grant is issued.

## Test plan
1. **Single requests.** Requester 0 DIV 100/7: rsp_data = 14, rsp_dbz = 0, rsp_id = 0, rsp_valid exactly 17 cycles after acceptance. Requester 0 MOD 100/7: rsp_data = 2.
2. **Divide by zero.** Requester 1 MOD 5/0: rsp_valid in the next cycle with rsp_data = 0, rsp_dbz = 1, rsp_id = 1. The RUN state is never entered.
3. **Round-robin order.** After reset, requesters 0 and 1 assert valid in the same cycle. Service order must be 0, then 1. Re-issue both together: the order continues 0, 1. With requester 1 held valid continuously and requester 0 re-requesting, grants alternate 0, 1, 0, 1 and neither is starved.
4. **Backpressure.** Hold rsp_ready low for 5 cycles in DONE: rsp_valid, rsp_data and rsp_id stay stable, req_ready stays 0 and busy stays 1. After release, IDLE follows in 1 cycle.
5. **Boundary values.**
   - 0xFFFF % 1 = 0.
   - 0xFFFF / 0xFFFF = 1.
   - 3 / 8 = 0 and 3 % 8 = 3.
   - 0 / 5 = 0.
   - 0xFFFF / 2 = 0x7FFF.
   - Randomized unsigned pairs compared against the `/` and `%` operators.
6. **Reset mid-operation.** Drop rst at step 8 of RUN: all outputs go to 0 immediately and no rsp_valid appears. After rst rises, a new request completes normally and ptr has restarted at 0.
